// File: rtl/mult_seq_taint_radix_if.sv
// Operand/result bundle for the taint-tracked radix multiplier.
// Every data and control signal travels with its _t taint shadow.
interface mult_seq_taint_radix_if #(
    parameter int WIDTH = 128
);
    logic                   start;
    logic                   start_t;
    logic                   signed_mode;
    logic                   signed_mode_t;
    logic [WIDTH-1:0]       multiplier;
    logic [WIDTH-1:0]       multiplier_t;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplicand_t;
    logic                   busy;
    logic                   busy_t;
    logic [2*WIDTH-1:0]     product;
    logic [2*WIDTH-1:0]     product_t;
    logic                   productDone;
    logic                   productDone_t;

    modport master (
        output start, start_t, signed_mode, signed_mode_t,
        output multiplier, multiplier_t, multiplicand, multiplicand_t,
        input  busy, busy_t, product, product_t, productDone, productDone_t
    );

    modport slave (
        input  start, start_t, signed_mode, signed_mode_t,
        input  multiplier, multiplier_t, multiplicand, multiplicand_t,
        output busy, busy_t, product, product_t, productDone, productDone_t
    );
endinterface

// File: rtl/mult_seq_taint_radix.sv
// Constant-time shift-add multiplier retiring DIGIT multiplier bits per cycle,
// with signed/unsigned mode, bitwise data taint and a sticky control taint.
// Signed results use a masked correction term in the last RUN cycle so the
// datapath does identical work for every operand and mode.
module mult_seq_taint_radix #(
    parameter int WIDTH = 128,
    parameter int DIGIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_seq_taint_radix_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;     // multiplier, next digit in the LSBs
    logic [PW-1:0]    b_sh_q, b_sh_d;     // extended multiplicand, pre-shifted to digit weight
    logic             sm_q, sm_d;
    logic             a_msb_q, a_msb_d;
    logic [PW-1:0]    acc_q, acc_d;       // running sum, doubles as product
    logic [WIDTH-1:0] c_sh_q, c_sh_d;     // combined operand taint, next digit in the LSBs
    logic             run_q, run_d;       // OR of all operand taint bits consumed so far
    logic [WIDTH-1:0] lo_q, lo_d;         // prefix-OR taint, filled from the top
    logic [PW-1:0]    pt_q, pt_d;
    logic             ct_q, ct_d;
    logic             busy_q, busy_d;
    logic             busy_t_q, busy_t_d;
    logic             done_q, done_d;

    logic             last;
    logic [PW-1:0]    term;
    logic [PW-1:0]    corr;
    logic [DIGIT-1:0] nb;
    logic             r;

    assign last = (cnt_q == CW'(N - 1));

    // Datapath terms for the current RUN cycle, computed unconditionally.
    always_comb begin
        term = '0;
        for (int j = 0; j < DIGIT; j++)
            term = term + ((b_sh_q << j) & {PW{a_sh_q[j]}});
        // b_sh_q << DIGIT equals the extended multiplicand x 2^WIDTH in the last cycle
        corr = (b_sh_q << DIGIT) & {PW{sm_q & a_msb_q & last}};
        r    = run_q;
        nb   = '0;
        for (int j = 0; j < DIGIT; j++) begin
            r     = r | c_sh_q[j];
            nb[j] = r;
        end
    end

    // Next-state logic for control, arithmetic and taint registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sm_d    = sm_q;
        a_msb_d = a_msb_q;
        acc_d   = acc_q;
        c_sh_d  = c_sh_q;
        run_d   = run_q;
        lo_d    = lo_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        case (state_q)
            S_IDLE: begin
                ct_d = bus.start_t;
                if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                a_sh_d  = bus.multiplier;
                a_msb_d = bus.multiplier[WIDTH-1];
                sm_d    = bus.signed_mode;
                b_sh_d  = bus.signed_mode ? {{WIDTH{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                          : {{WIDTH{1'b0}}, bus.multiplicand};
                acc_d   = '0;
                cnt_d   = '0;
                c_sh_d  = bus.multiplier_t | bus.multiplicand_t;
                run_d   = 1'b0;
                lo_d    = '0;
                ct_d    = ct_q | bus.signed_mode_t;
                pt_d    = {PW{ct_d}};
                state_d = S_RUN;
            end
            S_RUN: begin
                acc_d  = acc_q + term - corr;
                a_sh_d = a_sh_q >> DIGIT;
                b_sh_d = b_sh_q << DIGIT;
                c_sh_d = c_sh_q >> DIGIT;
                run_d  = nb[DIGIT-1];
                lo_d   = lo_q >> DIGIT;
                lo_d[WIDTH-1 -: DIGIT] = nb;
                cnt_d  = cnt_q + CW'(1);
                pt_d   = ct_q ? {PW{1'b1}} : {{WIDTH{run_d}}, lo_d};
                if (last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d   = (state_d == S_LOAD) || (state_d == S_RUN);
        busy_t_d = (state_d != S_IDLE) & ct_d;
        done_d   = (state_d == S_DONE);
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sm_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            acc_q    <= '0;
            c_sh_q   <= '0;
            run_q    <= 1'b0;
            lo_q     <= '0;
            pt_q     <= '0;
            ct_q     <= 1'b0;
            busy_q   <= 1'b0;
            busy_t_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sm_q     <= sm_d;
            a_msb_q  <= a_msb_d;
            acc_q    <= acc_d;
            c_sh_q   <= c_sh_d;
            run_q    <= run_d;
            lo_q     <= lo_d;
            pt_q     <= pt_d;
            ct_q     <= ct_d;
            busy_q   <= busy_d;
            busy_t_q <= busy_t_d;
            done_q   <= done_d;
        end
    end

    assign bus.product       = acc_q;
    assign bus.product_t     = pt_q;
    assign bus.busy          = busy_q;
    assign bus.busy_t        = busy_t_q;
    assign bus.productDone   = done_q;
    assign bus.productDone_t = ct_q;
endmodule

// File: tb/tb_mult_seq_taint_radix.sv
// Bench for mult_seq_taint_radix: three WIDTH=8 instances (DIGIT 1, 2, 4) share
// one stimulus; each has a cycle-level reference model checked every cycle,
// and directed transactions pin the model with hand-computed literals.
module tb_mult_seq_taint_radix;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       start = 1'b0, start_t = 1'b0, sm = 1'b0, smt = 1'b0;
    logic [7:0] a = '0, at = '0, b = '0, bt = '0;

    logic [2:0]       done_v, dt_v, busy_v, busy_t_v;
    logic [2:0][15:0] prod_v, pt_v;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference product straight from integer arithmetic.
    function automatic logic [15:0] mprod(input logic [7:0] x, input logic [7:0] y, input logic s);
        longint xa, ya;
        xa = s ? longint'($signed(x)) : longint'(x);
        ya = s ? longint'($signed(y)) : longint'(y);
        return 16'(xa * ya);
    endfunction

    // Bit k tainted iff any operand taint bit at or below min(k,7) is set.
    function automatic logic [15:0] mtaint(input logic [7:0] ta, input logic [7:0] tb2);
        logic [15:0] res;
        logic [7:0]  any;
        int          m;
        res = '0;
        any = ta | tb2;
        for (int k = 0; k < 16; k++) begin
            m = (k < 8) ? k : 7;
            res[k] = |(16'(any) & ((16'h1 << (m + 1)) - 16'h1));
        end
        return res;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int D  = 1 << g;
        localparam int NC = W / D;

        mult_seq_taint_radix_if #(.WIDTH(W)) bus ();
        mult_seq_taint_radix #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst(rst), .bus(bus));

        assign bus.start          = start;
        assign bus.start_t        = start_t;
        assign bus.signed_mode    = sm;
        assign bus.signed_mode_t  = smt;
        assign bus.multiplier     = a;
        assign bus.multiplier_t   = at;
        assign bus.multiplicand   = b;
        assign bus.multiplicand_t = bt;
        assign done_v[g]   = bus.productDone;
        assign dt_v[g]     = bus.productDone_t;
        assign busy_v[g]   = bus.busy;
        assign busy_t_v[g] = bus.busy_t;
        assign prod_v[g]   = bus.product;
        assign pt_v[g]     = bus.product_t;

        // ph: 0 idle, 1 load, 2..NC+1 run, NC+2 done
        int          ph  = 0;
        logic        ct  = 1'b0;
        logic [15:0] ep  = '0, ept = '0, lp = '0, lpt = '0;

        always @(negedge clk) begin
            if (!rst) begin
                ph = 0; ct = 1'b0; lp = '0; lpt = '0;
                chk($sformatf("d%0d_reset_outs", D),
                    64'({bus.busy, bus.busy_t, bus.productDone, bus.productDone_t, bus.product, bus.product_t}),
                    64'h0);
            end else begin
                chk($sformatf("d%0d_busy", D),   64'(bus.busy),          64'((ph >= 1) && (ph <= NC + 1)));
                chk($sformatf("d%0d_busy_t", D), 64'(bus.busy_t),        64'((ph >= 1) ? ct : 1'b0));
                chk($sformatf("d%0d_done", D),   64'(bus.productDone),   64'(ph == NC + 2));
                chk($sformatf("d%0d_done_t", D), 64'(bus.productDone_t), 64'(ct));
                if (ph == 0) begin
                    chk($sformatf("d%0d_hold_prod", D), 64'(bus.product),   64'(lp));
                    chk($sformatf("d%0d_hold_pt", D),   64'(bus.product_t), 64'(lpt));
                end
                if (ph == NC + 2) begin
                    lp  = ep;
                    lpt = ct ? 16'hFFFF : ept;
                    chk($sformatf("d%0d_product", D),   64'(bus.product),   64'(lp));
                    chk($sformatf("d%0d_product_t", D), 64'(bus.product_t), 64'(lpt));
                end
                if (ph == 1) begin
                    ep  = mprod(a, b, sm);
                    ept = mtaint(at, bt);
                end
                if (ph == 0) begin
                    ct = start_t;
                    if (start) ph = 1;
                end else if (ph == 1) begin
                    ct = ct | smt;
                    ph = 2;
                end else if (ph == NC + 2) begin
                    ph = 0;
                end else begin
                    ph = ph + 1;
                end
            end
        end
    end

    int          dc1 [3];
    int          dc2 [3];
    logic [15:0] rp  [3];
    logic [15:0] rpt [3];
    logic        rdt [3];
    logic        bt2;

    // One transaction started in cycle 0; records completion cycles per instance.
    task automatic txn(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] iat,
                       input logic [7:0] ibt, input logic is, input logic ist, input logic ist0,
                       input bit hold, input int pulse_k, input int rst_k, input int ncyc);
        for (int g = 0; g < 3; g++) begin
            dc1[g] = 0; dc2[g] = 0; rp[g] = '0; rpt[g] = '0; rdt[g] = 1'b0;
        end
        bt2 = 1'b0;
        @(posedge clk); #1;
        a = ia; b = ib; at = iat; bt = ibt; sm = is; smt = ist; start_t = ist0; start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            start_t = 1'b0;
            start   = hold || (k == pulse_k);
            if (k == rst_k) begin
                start = 1'b0;
                rst   = 1'b0;
                #1;
                chk("async_reset_busy",  64'({busy_v, busy_t_v}), 64'h0);
                chk("async_reset_done",  64'({done_v, dt_v}),     64'h0);
                chk("async_reset_prod",  64'(prod_v),             64'h0);
                chk("async_reset_pt",    64'(pt_v),               64'h0);
            end
            if (k == rst_k + 1) rst = 1'b1;
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (done_v[g]) begin
                    if (dc1[g] == 0) begin
                        dc1[g] = k; rp[g] = prod_v[g]; rpt[g] = pt_v[g]; rdt[g] = dt_v[g];
                    end else if (dc2[g] == 0) begin
                        dc2[g] = k;
                    end
                end
            end
            if (k == 2) bt2 = busy_t_v[0];
        end
        @(posedge clk); #1;
        start = 1'b0; start_t = 1'b0; smt = 1'b0;
        repeat (14) @(posedge clk);
    endtask

    task automatic chk_lat(input string nm);
        chk({nm, "_lat_d1"}, 64'(dc1[0]), 64'd10);
        chk({nm, "_lat_d2"}, 64'(dc1[1]), 64'd6);
        chk({nm, "_lat_d4"}, 64'(dc1[2]), 64'd4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'({busy_v, busy_t_v, done_v, dt_v}), 64'h0);
        chk("reset_prod", 64'(prod_v), 64'h0);
        chk("reset_pt",   64'(pt_v),   64'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // unsigned 255 x 255
        txn(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 12);
        chk_lat("u255");
        for (int g = 0; g < 3; g++) chk($sformatf("u255_prod_%0d", g), 64'(rp[g]), 64'hFE01);
        chk("u255_pt",  64'(rpt[0]), 64'h0);
        chk("u255_dt",  64'(rdt[0]), 64'h0);

        // signed -3 x 5
        txn(8'hFD, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 12);
        chk_lat("s_m3x5");
        for (int g = 0; g < 3; g++) chk($sformatf("s_m3x5_prod_%0d", g), 64'(rp[g]), 64'hFFF1);

        // signed -128 x -128
        txn(8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 12);
        for (int g = 0; g < 3; g++) chk($sformatf("s_80x80_prod_%0d", g), 64'(rp[g]), 64'h4000);

        // start pulsed during RUN is ignored: 90 x 195
        txn(8'h5A, 8'hC3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 12);
        chk("pulse_prod", 64'(rp[0]), 64'h448E);
        chk("pulse_no_second_done", 64'(dc2[0] + dc2[1] + dc2[2]), 64'h0);

        // multiplicand bit 0 tainted
        txn(8'h12, 8'h34, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 12);
        chk("taint_b0_pt", 64'(rpt[0]), 64'hFFFF);
        chk("taint_b0_dt", 64'(rdt[0]), 64'h0);

        // multiplier bit 4 tainted
        txn(8'h12, 8'h34, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 12);
        for (int g = 0; g < 3; g++) chk($sformatf("taint_a4_pt_%0d", g), 64'(rpt[g]), 64'hFFF0);

        // tainted start with clean data
        txn(8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 12);
        chk("start_t_busy_t", 64'(bt2),    64'h1);
        chk("start_t_dt",     64'(rdt[0]), 64'h1);
        chk("start_t_pt",     64'(rpt[0]), 64'hFFFF);

        // tainted mode with clean data
        txn(8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 12);
        chk("smt_busy_t", 64'(bt2),    64'h1);
        chk("smt_dt",     64'(rdt[2]), 64'h1);
        chk("smt_pt",     64'(rpt[1]), 64'hFFFF);

        // start held high: back-to-back issue every N+3 cycles
        txn(8'h03, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 21);
        chk_lat("b2b");
        chk("b2b_second_d1", 64'(dc2[0]), 64'd21);
        chk("b2b_second_d2", 64'(dc2[1]), 64'd13);
        chk("b2b_second_d4", 64'(dc2[2]), 64'd9);
        chk("b2b_prod", 64'(rp[0]), 64'h0015);

        // asynchronous reset mid-RUN aborts without a done pulse
        txn(8'hAA, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 12);
        chk("abort_no_done", 64'(dc1[0] + dc1[1] + dc1[2]), 64'h0);

        // clean transaction after reset: 127 x -127
        txn(8'h7F, 8'h81, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 12);
        chk_lat("post_rst");
        for (int g = 0; g < 3; g++) chk($sformatf("post_rst_prod_%0d", g), 64'(rp[g]), 64'hC0FF);

        // random operands, both modes, random data taints; model checks every cycle
        for (int i = 0; i < 8; i++) begin
            txn(8'($urandom), 8'($urandom), 8'($urandom_range(0, 255) & 8'h81 & 8'($urandom)),
                8'(1 << $urandom_range(0, 7)), 1'(i & 1), 1'b0, 1'b0, 1'b0, 0, 0, 12);
            chk($sformatf("rand%0d_lat", i), 64'(dc1[0]), 64'd10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
